// File: rtl/fpu_mult_ctrl.sv
// Request/response sequencer around a combinational single-precision multiplier.
// Optional IEEE exception flags are built when FPU_MULT_FLAGS_EN is defined.
module fpu_mult_ctrl #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [2:0]       req_rm,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [2:0]       frm,
    input  logic             flush,
    output logic             mul_on,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic [2:0]       mul_rm,
    input  logic [31:0]      mul_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_illegal,
    output logic [4:0]       rsp_fflags
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RM_W   = 3;
    localparam int unsigned FLAG_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mul_on_q, mul_on_d;
    logic [DATA_W-1:0]   mul_a_q, mul_a_d;
    logic [DATA_W-1:0]   mul_b_q, mul_b_d;
    logic [RM_W-1:0]     mul_rm_q, mul_rm_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
    logic                rsp_illegal_q, rsp_illegal_d;
    logic [FLAG_W-1:0]   rsp_fflags_q, rsp_fflags_d;

    logic [RM_W-1:0]     eff_rm_c;
    logic                rm_illegal_c;
    logic                accept_c;
    logic [FLAG_W-1:0]   flags_c;

    // Dynamic rounding mode (111) defers to the CSR; 101..111 are reserved.
    assign eff_rm_c     = (req_rm == 3'b111) ? frm : req_rm;
    assign rm_illegal_c = (eff_rm_c >= 3'd5);

    assign req_ready = !flush && ((state_q == IDLE) || ((state_q == DONE) && rsp_ready));
    assign accept_c  = req_valid && req_ready;

`ifdef FPU_MULT_FLAGS_EN
    logic a_exp_ff, b_exp_ff, a_man_nz, b_man_nz;
    logic a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic res_inf, flag_nv, flag_of;

    // Flags are derived from the held operands and the result being captured.
    assign a_exp_ff = &mul_a_q[30:23];
    assign b_exp_ff = &mul_b_q[30:23];
    assign a_man_nz = |mul_a_q[22:0];
    assign b_man_nz = |mul_b_q[22:0];
    assign a_snan   = a_exp_ff && a_man_nz && !mul_a_q[22];
    assign b_snan   = b_exp_ff && b_man_nz && !mul_b_q[22];
    assign a_inf    = a_exp_ff && !a_man_nz;
    assign b_inf    = b_exp_ff && !b_man_nz;
    assign a_zero   = ~|mul_a_q[30:0];
    assign b_zero   = ~|mul_b_q[30:0];
    assign res_inf  = (&mul_out[30:23]) && !(|mul_out[22:0]);
    assign flag_nv  = a_snan || b_snan || (a_inf && b_zero) || (a_zero && b_inf);
    assign flag_of  = res_inf && !a_exp_ff && !b_exp_ff;
    assign flags_c  = {flag_nv, 1'b0, flag_of, 1'b0, flag_of};
`else
    assign flags_c  = '0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mul_on_d      = mul_on_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        mul_rm_d      = mul_rm_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_illegal_d = rsp_illegal_q;
        rsp_fflags_d  = rsp_fflags_q;

        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            mul_on_d    = 1'b0;
            rsp_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                BUSY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d       = DONE;
                        cnt_d         = '0;
                        mul_on_d      = 1'b0;
                        rsp_valid_d   = 1'b1;
                        rsp_data_d    = mul_out;
                        rsp_illegal_d = 1'b0;
                        rsp_fflags_d  = flags_c;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // A new request overrides the DONE->IDLE retirement so there is no bubble.
            if (accept_c) begin
                mul_a_d   = req_a;
                mul_b_d   = req_b;
                mul_rm_d  = eff_rm_c;
                rsp_tag_d = req_tag;
                if (rm_illegal_c) begin
                    state_d       = DONE;
                    cnt_d         = '0;
                    mul_on_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = '0;
                    rsp_illegal_d = 1'b1;
                    rsp_fflags_d  = '0;
                end else begin
                    state_d     = BUSY;
                    cnt_d       = CNT_W'(LATENCY);
                    mul_on_d    = 1'b1;
                    rsp_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mul_on_q      <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mul_rm_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_tag_q     <= '0;
            rsp_illegal_q <= 1'b0;
            rsp_fflags_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mul_on_q      <= mul_on_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            mul_rm_q      <= mul_rm_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_illegal_q <= rsp_illegal_d;
            rsp_fflags_q  <= rsp_fflags_d;
        end
    end

    assign mul_on      = mul_on_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_rm      = mul_rm_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_illegal = rsp_illegal_q;
    assign rsp_fflags  = rsp_fflags_q;

endmodule

// File: doc/fpu_mult_ctrl.md
FPU_MULT_CTRL -- requirements
Module: fpu_mult_ctrl

Interface
REQ-001 SHALL: param LATENCY, default 1, cycles from request acceptance to result capture; legal range 1..8.
REQ-002 SHALL: param TAG_W, default 5, width of destination tag.
REQ-003 SHALL: clk  in  1  sole clock, rising edge.
REQ-004 SHALL: reset  in  1  asynchronous, active-low.
REQ-005 SHALL: req_valid/req_ready  in/out  1/1  request handshake.
REQ-006 SHALL: req_a, req_b  in  32/32  IEEE-754 single operands.
REQ-007 SHALL: req_rm  in  3  instruction rounding mode; req_tag  in  TAG_W  destination tag.
REQ-008 SHALL: frm  in  3  CSR dynamic rounding mode.
REQ-009 SHALL: flush  in  1  synchronous pipeline kill.
REQ-010 SHALL: mul_on  out  1, mul_a/mul_b  out  32/32, mul_rm  out  3  to the combinational multiplier.
REQ-011 SHALL: mul_out  in  32  multiplier result.
REQ-012 SHALL: rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-013 SHALL: rsp_data  out  32, rsp_tag  out  TAG_W, rsp_illegal  out  1, rsp_fflags  out  5 {NV,DZ,OF,UF,NX}.

Function
REQ-014 SHALL: FSM states IDLE, BUSY, DONE.
REQ-015 SHALL: req_ready = !flush & (IDLE | (DONE & rsp_ready)); accept = req_valid & req_ready.
REQ-016 SHALL: on accept, register req_a, req_b, req_tag, and effective rm (req_rm, or frm when req_rm=3'b111) into mul_a, mul_b, rsp_tag, mul_rm.
REQ-017 SHALL: effective rm of 3'b101, 3'b110 or 3'b111 -> go directly to DONE next cycle, rsp_data=0, rsp_illegal=1, rsp_fflags=0, mul_on stays 0.
REQ-018 SHALL: legal accept -> BUSY, load counter with LATENCY, mul_on=1 throughout BUSY, operands held stable.
REQ-019 SHALL: in BUSY, decrement counter each cycle; at edge where counter==1 capture mul_out into rsp_data, rsp_illegal=0, enter DONE, mul_on drops.
REQ-020 SHALL: rsp_valid=1 exactly in DONE; accept-to-rsp_valid latency = LATENCY cycles (legal) or 1 cycle (illegal).
REQ-021 SHALL: DONE holds rsp_* stable until rsp_ready; on rsp_ready with no accept -> IDLE; with accept -> BUSY (or DONE if illegal), no bubble.
REQ-022 SHALL: flush in any state -> IDLE next edge, rsp_valid=0, mul_on=0, in-flight result discarded; flush beats a same-cycle accept and a same-cycle rsp_ready.
REQ-023 SHALL: inputs other than flush/rsp_ready ignored in BUSY.

Reset
REQ-024 SHALL: reset low -> state IDLE, counter 0, mul_on 0, rsp_valid 0, all data/tag/flag registers 0, immediately (asynchronous).
REQ-025 SHALL: reset mid-BUSY discards the operation; first accept possible on first edge after reset deasserts.

Configuration
REQ-026 SHALL: macro FPU_MULT_FLAGS_EN defined -> compute rsp_fflags at capture: NV if either operand sNaN (exp FF, mant!=0, mant[22]=0) or inf x zero; OF and NX if captured result is infinity and neither operand is inf/NaN; DZ, UF always 0.
REQ-027 SHALL: macro FPU_MULT_FLAGS_EN undefined -> rsp_fflags tied to 5'b00000, no flag logic synthesized.

Verification
REQ-028 SHALL: LATENCY=1, 0x40400000 x 0x40000000, rm=000, tag=3 -> rsp_valid 1 cycle after accept, rsp_data 0x40C00000, rsp_tag 3, rsp_illegal 0.
REQ-029 SHALL: req_rm=111, frm=101 -> rsp_illegal 1, rsp_data 0, mul_on never asserted; req_rm=111, frm=001 -> mul_rm 001.
REQ-030 SHALL: LATENCY=4, rsp_ready held 0 for 6 cycles after rsp_valid -> rsp_data stable, req_ready 0; then rsp_ready=1 with req_valid=1 -> new op accepted same edge, mul_on next cycle.
REQ-031 SHALL: LATENCY=4, flush in 2nd BUSY cycle -> IDLE next edge, no rsp_valid for that op; req_ready 0 during flush cycle.
REQ-032 SHALL: FLAGS_EN, 0x7F800001 x 0x3F800000 -> rsp_fflags 10000; 0x7F800000 x 0x00000000 -> 10000; 0x7F000000 x 0x7F000000, rm=000 -> rsp_data 0x7F800000, rsp_fflags 00101.
REQ-033 SHALL: reset asserted mid-BUSY -> rsp_valid, mul_on 0 immediately without clock; later op completes normally.
